// File: rtl/odd_parity_serializer.sv
// Serial framer: start bit, DATA_W data bits LSB first, odd-parity bit, then
// STOP_BITS stop bits, with a valid/ready word input and back-to-back frames.
module odd_parity_serializer #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              par_out,
  output logic              frame_done
);

  localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        stop_q, stop_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_busy_q, tx_busy_d;
  logic              frame_done_q, frame_done_d;
  logic              bit_last, stop_end, accept;

  // Next-state logic; state_q names the symbol currently on tx_out
  always_comb begin
    bit_last  = (cyc_q == CYC_LAST);
    stop_end  = (state_q == ST_STOP) && bit_last && (stop_q == STOP_LAST);
    din_ready = !rst && ((state_q == ST_IDLE) || stop_end);
    accept    = din_valid && din_ready;

    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          cyc_d   = {CYC_W{1'b0}};
          shreg_d = din;
          par_d   = odd_parity(din);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_last) begin
          state_d = ST_DATA;
          cyc_d   = {CYC_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          cyc_d   = {CYC_W{1'b0}};
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_last) begin
          state_d = ST_STOP;
          cyc_d   = {CYC_W{1'b0}};
          stop_d  = 2'd0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_last) begin
          cyc_d = {CYC_W{1'b0}};
          if (stop_q == STOP_LAST) begin
            // A word accepted on the final stop clock starts its frame with no idle gap
            if (accept) begin
              state_d = ST_START;
              shreg_d = din;
              par_d   = odd_parity(din);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = stop_q + 2'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it
  always_comb begin
    case (state_d)
      ST_IDLE:   tx_out_d = 1'b1;
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = shreg_d[0];
      ST_PARITY: tx_out_d = par_d;
      ST_STOP:   tx_out_d = 1'b1;
      default:   tx_out_d = 1'b1;
    endcase
    tx_busy_d    = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_STOP) && (cyc_d == CYC_LAST) && (stop_d == STOP_LAST);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cyc_q        <= {CYC_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      stop_q       <= 2'd0;
      shreg_q      <= {DATA_W{1'b0}};
      par_q        <= 1'b0;
      tx_out_q     <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      stop_q       <= stop_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      tx_out_q     <= tx_out_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_busy    = tx_busy_q;
  assign par_out    = par_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_odd_parity_serializer.sv
// Scoreboard bench: stimulus pushes expected frames, negedge monitors collect
// tx_out per frame and compare on frame_done.
module tb_odd_parity_serializer;

  typedef struct {
    logic [63:0] bits;
    int          len;
    logic [3:0]  din;
    logic        par;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] din_a = 4'h0, din_b = 4'h0;
  logic din_valid_a = 1'b0, din_valid_b = 1'b0;
  logic din_ready_a, tx_out_a, tx_busy_a, par_out_a, frame_done_a;
  logic din_ready_b, tx_out_b, tx_busy_b, par_out_b, frame_done_b;

  int tests = 0;
  int failed = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [63:0] cur_a = 64'd0, cur_b = 64'd0;
  int len_a = 0, len_b = 0;
  int drops, f1, f2, fd_cnt;
  exp_t e_hand;

  always #5 clk = ~clk;

  odd_parity_serializer #(.DATA_W(4), .BIT_CYCLES(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
    .tx_out(tx_out_a), .tx_busy(tx_busy_a), .par_out(par_out_a), .frame_done(frame_done_a)
  );

  odd_parity_serializer #(.DATA_W(4), .BIT_CYCLES(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .tx_out(tx_out_b), .tx_busy(tx_busy_b), .par_out(par_out_b), .frame_done(frame_done_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line model: each symbol held bc samples; parity makes the data+parity ones count odd
  function automatic exp_t make_exp(input logic [3:0] d, input int bc, input int sb);
    exp_t e;
    logic [7:0] sym;
    int ones, n;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(d[i]);
    sym = 8'hFF;
    sym[0] = 1'b0;
    for (int i = 0; i < 4; i++) sym[1+i] = d[i];
    sym[5] = (ones % 2 == 0);
    e.bits = 64'd0;
    n = 0;
    for (int s = 0; s < 6 + sb; s++)
      for (int c = 0; c < bc; c++) begin
        e.bits[n] = sym[s];
        n++;
      end
    e.len = n;
    e.din = d;
    e.par = sym[5];
    return e;
  endfunction

  task automatic check_frame(input string tag, input logic [63:0] bits, input int len,
                             input logic par_now, input int bc, input exp_t e);
    logic [3:0] data;
    logic p;
    chk({tag, "_len"}, len, e.len);
    chk({tag, "_bits"}, bits, e.bits);
    chk({tag, "_par_out"}, par_now, e.par);
    for (int i = 0; i < 4; i++) data[i] = bits[(1 + i) * bc + bc / 2];
    p = bits[5 * bc + bc / 2];
    chk({tag, "_deser_data"}, data, e.din);
    chk({tag, "_odd_ones"}, ^{data, p}, 1'b1);
  endtask

  // Monitor for the 1-clock-per-bit instance
  always @(negedge clk) begin
    if (rst) begin
      len_a = 0;
      cur_a = 64'd0;
    end else begin
      if (tx_busy_a && len_a < 64) begin
        cur_a[len_a] = tx_out_a;
        len_a++;
      end
      if (frame_done_a) begin
        chk("a_fd_expected", q_a.size() > 0, 1'b1);
        if (q_a.size() > 0) check_frame("a", cur_a, len_a, par_out_a, 1, q_a.pop_front());
        len_a = 0;
        cur_a = 64'd0;
      end
    end
  end

  // Monitor for the 4-clocks-per-bit, two-stop-bit instance
  always @(negedge clk) begin
    if (rst) begin
      len_b = 0;
      cur_b = 64'd0;
    end else begin
      if (tx_busy_b && len_b < 64) begin
        cur_b[len_b] = tx_out_b;
        len_b++;
      end
      if (frame_done_b) begin
        chk("b_fd_expected", q_b.size() > 0, 1'b1);
        if (q_b.size() > 0) check_frame("b", cur_b, len_b, par_out_b, 4, q_b.pop_front());
        len_b = 0;
        cur_b = 64'd0;
      end
    end
  end

  task automatic send_a(input logic [3:0] d, input bit keep, input bit do_push);
    logic rdy;
    bit got;
    got = 1'b0;
    din_a = d;
    din_valid_a = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      rdy = din_ready_a;
      @(posedge clk); #1;
      if (rdy) got = 1'b1;
    end
    if (got && do_push) q_a.push_back(make_exp(d, 1, 1));
    chk("a_accept", got, 1'b1);
    if (!keep) din_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d);
    logic rdy;
    bit got;
    got = 1'b0;
    din_b = d;
    din_valid_b = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      rdy = din_ready_b;
      @(posedge clk); #1;
      if (rdy) got = 1'b1;
    end
    if (got) q_b.push_back(make_exp(d, 4, 2));
    chk("b_accept", got, 1'b1);
    din_valid_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (tx_busy_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_idle_timeout", tx_busy_a, 1'b0);
  endtask

  initial begin
    // Reset state, sampled while rst is still high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_out", tx_out_a, 1'b1);
    chk("rst_tx_busy", tx_busy_a, 1'b0);
    chk("rst_par_out", par_out_a, 1'b0);
    chk("rst_frame_done", frame_done_a, 1'b0);
    chk("rst_din_ready", din_ready_a, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_din_ready", din_ready_a, 1'b1);

    // Test 1: all-zero word, hand frame 0,0,0,0,0,1,1
    e_hand.bits = 64'h60; e_hand.len = 7; e_hand.din = 4'h0; e_hand.par = 1'b1;
    q_a.push_back(e_hand);
    send_a(4'b0000, 1'b0, 1'b0);
    chk("t1_par_out", par_out_a, 1'b1);
    wait_idle_a();

    // Test 2: 4'b1011, hand frame 0,1,1,0,1,0,1 and ready profile
    e_hand.bits = 64'h56; e_hand.len = 7; e_hand.din = 4'hB; e_hand.par = 1'b0;
    q_a.push_back(e_hand);
    send_a(4'b1011, 1'b0, 1'b0);
    chk("t2_par_out", par_out_a, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("t2_ready_clk%0d", k), din_ready_a, (k == 7) ? 1'b1 : 1'b0);
      if (k < 7) begin
        @(posedge clk); #1;
      end
    end
    wait_idle_a();

    // Test 3: back-to-back words with valid held
    drops = 0; f1 = -1; f2 = -1;
    fork
      begin
        send_a(4'h5, 1'b1, 1'b1);
        send_a(4'hE, 1'b0, 1'b1);
      end
      begin
        for (int k = 0; k < 20 && !tx_busy_a; k++) begin
          @(posedge clk); #1;
        end
        for (int j = 1; j <= 14; j++) begin
          if (!tx_busy_a) drops++;
          if (frame_done_a) begin
            if (f1 < 0) f1 = j;
            else f2 = j;
          end
          @(posedge clk); #1;
        end
      end
    join
    chk("t3_busy_drops", drops, 0);
    chk("t3_fd1_clock", f1, 7);
    chk("t3_fd2_clock", f2, 14);
    chk("t3_idle_after", tx_busy_a, 1'b0);

    // Test 4: reset on the third data bit aborts the frame
    send_a(4'h6, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_tx_out", tx_out_a, 1'b1);
    chk("t4_tx_busy", tx_busy_a, 1'b0);
    chk("t4_din_ready", din_ready_a, 1'b0);
    chk("t4_par_out", par_out_a, 1'b0);
    rst = 1'b0;
    fd_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (frame_done_a) fd_cnt++;
      @(posedge clk); #1;
    end
    chk("t4_no_frame_done", fd_cnt, 0);
    send_a(4'hA, 1'b0, 1'b1);
    wait_idle_a();

    // Test 5: 4 clocks per bit, two stop bits
    send_b(4'h9);
    chk("t5_par_out", par_out_b, 1'b1);

    // Test 6: every data value
    for (int v = 0; v < 16; v++) send_a(4'(v), 1'b0, 1'b1);

    for (int k = 0; k < 400 && (q_a.size() + q_b.size()) > 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_pending", q_a.size() + q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
